// File: rtl/id_stage_pipe.sv
// RV32I/RV32E decode stage with register file and one registered output slot.
// Optional ID_BYPASS_EN forwards same-cycle writeback into captured/held operands.
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_wr,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_write_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_imm_data,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_func3,
  output logic [3:0]      o_alu_ctrl,
  output logic            o_illegal
);
  localparam int RA_W = $clog2(NREGS);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  logic [XLEN-1:0] rf [NREGS];
  logic            wr_en;
  logic            accept;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm, rs1_val, rs2_val;
  logic [3:0]      alu;
  logic            known, use_rs1, use_rs2, use_rd, illegal;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready && !i_flush;
  assign wr_en   = i_wr && (i_rd_addr != 5'd0) && (int'(i_rd_addr) < NREGS);

  assign opcode = i_instr[6:0];
  assign func3  = i_instr[14:12];
  assign rd     = i_instr[11:7];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[i_rd_addr[RA_W-1:0]] <= i_write_data;
    end
  end

  // Register file is read before the same-edge write lands.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && int'(rs1) < NREGS) rs1_val = rf[rs1[RA_W-1:0]];
    if (rs2 != 5'd0 && int'(rs2) < NREGS) rs2_val = rf[rs2[RA_W-1:0]];
`ifdef ID_BYPASS_EN
    if (wr_en && i_rd_addr == rs1) rs1_val = i_write_data;
    if (wr_en && i_rd_addr == rs2) rs2_val = i_write_data;
`endif
  end

  always_comb begin
    imm     = '0;
    alu     = 4'b0000;
    known   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm    = {{(XLEN-31){i_instr[31]}}, i_instr[30:12], 12'b0};
        use_rd = 1'b1;
      end
      OP_JAL: begin
        imm    = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        use_rd = 1'b1;
      end
      OP_JALR, OP_LOAD: begin
        imm     = {{(XLEN-11){i_instr[31]}}, i_instr[30:20]};
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_IMM: begin
        imm     = {{(XLEN-11){i_instr[31]}}, i_instr[30:20]};
        alu     = {(func3 == 3'b101) && i_instr[30], func3};
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_BRANCH: begin
        imm     = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_STORE: begin
        imm     = {{(XLEN-11){i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_OP: begin
        alu     = {i_instr[30], func3};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      default: known = 1'b0;
    endcase
    illegal = !known
            || (use_rs1 && int'(rs1) >= NREGS)
            || (use_rs2 && int'(rs2) >= NREGS)
            || (use_rd  && int'(rd)  >= NREGS);
  end

  // Flush outranks accept; a stalled bundle holds everything except bypassed operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_pc       <= '0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_rs1_addr <= '0;
      o_rs2_addr <= '0;
      o_rd_addr  <= '0;
      o_imm_data <= '0;
      o_opcode   <= '0;
      o_func3    <= '0;
      o_alu_ctrl <= '0;
      o_illegal  <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_pc       <= i_pc;
      o_rs1_data <= rs1_val;
      o_rs2_data <= rs2_val;
      o_rs1_addr <= rs1;
      o_rs2_addr <= rs2;
      o_rd_addr  <= rd;
      o_imm_data <= imm;
      o_opcode   <= opcode;
      o_func3    <= func3;
      o_alu_ctrl <= alu;
      o_illegal  <= illegal;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end else begin
`ifdef ID_BYPASS_EN
      if (o_valid && wr_en && i_rd_addr == o_rs1_addr) o_rs1_data <= i_write_data;
      if (o_valid && wr_en && i_rd_addr == o_rs2_addr) o_rs2_data <= i_write_data;
`endif
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: an RV32I (NREGS=32) and an RV32E (NREGS=16)
// instance share stimulus; each has its own reference model and expected queue.
module tb_id_stage_pipe;
  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        ill;
  } bundle_t;

  logic clk = 1'b0;
  logic rst, i_valid, i_flush, i_wr, i_ready;
  logic [31:0] i_instr, i_pc, i_write_data;
  logic [4:0]  i_rd_addr;

  logic        rdy0, v0, ill0, rdy1, v1, ill1;
  logic [31:0] pc0, r1d0, r2d0, imm0, pc1, r1d1, r2d1, imm1;
  logic [4:0]  r1a0, r2a0, rda0, r1a1, r2a1, rda1;
  logic [6:0]  op0, op1;
  logic [2:0]  f30, f31;
  logic [3:0]  alu0, alu1;

  int checks = 0;
  int errors = 0;
  logic    exp_valid;
  logic [31:0] rf_m [2][32];
  bundle_t q0[$];
  bundle_t q1[$];

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NREGS(32)) d32 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy0), .i_instr(i_instr), .i_pc(i_pc),
    .i_flush(i_flush), .i_wr(i_wr), .i_rd_addr(i_rd_addr), .i_write_data(i_write_data),
    .o_valid(v0), .i_ready(i_ready), .o_pc(pc0), .o_rs1_data(r1d0), .o_rs2_data(r2d0),
    .o_rs1_addr(r1a0), .o_rs2_addr(r2a0), .o_rd_addr(rda0), .o_imm_data(imm0),
    .o_opcode(op0), .o_func3(f30), .o_alu_ctrl(alu0), .o_illegal(ill0));

  id_stage_pipe #(.XLEN(32), .NREGS(16)) d16 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy1), .i_instr(i_instr), .i_pc(i_pc),
    .i_flush(i_flush), .i_wr(i_wr), .i_rd_addr(i_rd_addr), .i_write_data(i_write_data),
    .o_valid(v1), .i_ready(i_ready), .o_pc(pc1), .o_rs1_data(r1d1), .o_rs2_data(r2d1),
    .o_rs1_addr(r1a1), .o_rs2_addr(r2a1), .o_rd_addr(rda1), .o_imm_data(imm1),
    .o_opcode(op1), .o_func3(f31), .o_alu_ctrl(alu1), .o_illegal(ill1));

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bundle_t act0();
    return {pc0, r1d0, r2d0, r1a0, r2a0, rda0, imm0, op0, f30, alu0, ill0};
  endfunction

  function automatic bundle_t act1();
    return {pc1, r1d1, r2d1, r1a1, r2a1, rda1, imm1, op1, f31, alu1, ill1};
  endfunction

  function automatic logic [31:0] read_m(int k, int n, int a, logic w, int wa, logic [31:0] wd);
    if (a == 0 || a >= n) return 32'h0;
`ifdef ID_BYPASS_EN
    if (w && wa == a) return wd;
`endif
    return rf_m[k][a];
  endfunction

  // Expected bundle from the ISA field rules, using plain arithmetic on the word.
  function automatic bundle_t predict(int k, logic [31:0] ins, logic [31:0] pc,
                                      logic w, logic [4:0] wa, logic [31:0] wd);
    bundle_t b;
    int n = (k == 0) ? 32 : 16;
    int r1 = int'((ins >> 15) % 32);
    int r2 = int'((ins >> 20) % 32);
    int rd = int'((ins >> 7) % 32);
    int f3 = int'((ins >> 12) % 8);
    int b30 = int'((ins >> 30) % 2);
    logic [31:0] sg = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    bit known = 1, u1 = 0, u2 = 0, ud = 0;
    int alu = 0;
    b.imm = 32'h0;
    case (ins % 128)
      32'h37, 32'h17: begin b.imm = (ins / 4096) * 4096; ud = 1; end
      32'h6F: begin
        b.imm = (sg << 20) | (((ins >> 12) % 256) << 12) | (((ins >> 20) % 2) << 11)
              | (((ins >> 21) % 1024) << 1);
        ud = 1;
      end
      32'h67, 32'h03: begin b.imm = (sg << 12) | (ins >> 20); u1 = 1; ud = 1; end
      32'h13: begin
        b.imm = (sg << 12) | (ins >> 20); u1 = 1; ud = 1;
        alu = f3 + ((f3 == 5) ? 8 * b30 : 0);
      end
      32'h63: begin
        b.imm = (sg << 12) | (((ins >> 7) % 2) << 11) | (((ins >> 25) % 64) << 5)
              | (((ins >> 8) % 16) << 1);
        u1 = 1; u2 = 1;
      end
      32'h23: begin
        b.imm = (sg << 12) | ((ins >> 25) << 5) | ((ins >> 7) % 32);
        u1 = 1; u2 = 1;
      end
      32'h33: begin u1 = 1; u2 = 1; ud = 1; alu = f3 + 8 * b30; end
      default: known = 0;
    endcase
    b.pc   = pc;
    b.rs1a = 5'(r1);
    b.rs2a = 5'(r2);
    b.rda  = 5'(rd);
    b.op   = 7'(ins % 128);
    b.f3   = 3'(f3);
    b.alu  = 4'(alu);
    b.ill  = !known || (u1 && r1 >= n) || (u2 && r2 >= n) || (ud && rd >= n);
    b.rs1d = read_m(k, n, r1, w, int'(wa), wd);
    b.rs2d = read_m(k, n, r2, w, int'(wa), wd);
    return b;
  endfunction

  // Monitor: any presented bundle must match the queue head; it retires on consume or flush.
  always @(negedge clk) begin
    if (!rst) begin
      if (v0) begin
        if (q0.size() == 0) chk("d32_unexpected_valid", 1, 0);
        else begin
          chk("d32_bundle", act0(), q0[0]);
          if (i_ready || i_flush) void'(q0.pop_front());
        end
      end
      if (v1) begin
        if (q1.size() == 0) chk("d16_unexpected_valid", 1, 0);
        else begin
          chk("d16_bundle", act1(), q1[0]);
          if (i_ready || i_flush) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic step(logic v, logic [31:0] ins, logic [31:0] pc, logic fl,
                      logic w, logic [4:0] wa, logic [31:0] wd, logic rdy);
    logic acc;
    bundle_t t;
    @(posedge clk);
    #1;
    chk("d32_valid", v0, exp_valid);
    chk("d16_valid", v1, exp_valid);
    i_valid = v; i_instr = ins; i_pc = pc; i_flush = fl;
    i_wr = w; i_rd_addr = wa; i_write_data = wd; i_ready = rdy;
    #1;
    chk("d32_ready", rdy0, !exp_valid || rdy);
    chk("d16_ready", rdy1, !exp_valid || rdy);
    acc = v && (!exp_valid || rdy) && !fl;
    if (acc) begin
      q0.push_back(predict(0, ins, pc, w, wa, wd));
      q1.push_back(predict(1, ins, pc, w, wa, wd));
    end
`ifdef ID_BYPASS_EN
    if (exp_valid && !rdy && !fl && w && wa != 0) begin
      if (q0.size() > 0) begin
        t = q0[0];
        if (t.rs1a == wa) t.rs1d = wd;
        if (t.rs2a == wa) t.rs2d = wd;
        q0[0] = t;
      end
      if (q1.size() > 0 && wa < 16) begin
        t = q1[0];
        if (t.rs1a == wa) t.rs1d = wd;
        if (t.rs2a == wa) t.rs2d = wd;
        q1[0] = t;
      end
    end
`endif
    if (w && wa != 0) rf_m[0][wa] = wd;
    if (w && wa != 0 && wa < 16) rf_m[1][wa] = wd;
    if (fl) exp_valid = 1'b0;
    else if (acc) exp_valid = 1'b1;
    else if (rdy) exp_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_valid = 0; i_flush = 0; i_wr = 0; i_ready = 0;
    i_instr = 0; i_pc = 0; i_rd_addr = 0; i_write_data = 0;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) for (int r = 0; r < 32; r++) rf_m[k][r] = 32'h0;
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("d32_reset_valid", v0, 0);
    chk("d16_reset_valid", v1, 0);
    chk("d32_reset_outputs", act0(), '0);
    chk("d16_reset_outputs", act1(), '0);
  endtask

  task automatic rand_step();
    logic [31:0] ins;
    logic [6:0]  op;
    logic [4:0]  wa;
    logic        w;
    case ($urandom_range(0, 9))
      0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67; 4: op = 7'h63;
      5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13; 8: op = 7'h33;
      default: op = 7'($urandom);
    endcase
    ins = $urandom;
    ins[6:0] = op;
    w = ($urandom_range(0, 1) == 1);
    case ($urandom_range(0, 2))
      0: wa = ins[19:15];
      1: wa = ins[24:20];
      default: wa = 5'($urandom);
    endcase
    step($urandom_range(0, 4) != 0, ins, $urandom, $urandom_range(0, 15) == 0,
         w, wa, $urandom, $urandom_range(0, 9) < 7);
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    // addi x5,x0,2047
    step(1, 32'h7FF00293, 32'h100, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 5, 32'h7FF, 1);
    step(0, 0, 0, 0, 1, 6, 32'h10, 1);
    // add x6,x6,x5 without and with a same-cycle write of x5
    step(1, 32'h00530333, 32'h104, 0, 0, 0, 0, 1);
    step(1, 32'h00530333, 32'h108, 0, 1, 5, 32'h123, 1);
    // jal x7,-28 then bge x7,x6,16 back to back
    step(1, 32'hFE5FF3EF, 32'h10C, 0, 0, 0, 0, 1);
    step(1, 32'h0063D863, 32'h110, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // three-cycle stall with a writeback to a held source
    step(1, 32'h00530333, 32'h200, 0, 0, 0, 0, 1);
    step(1, 32'h0063D863, 32'h204, 0, 1, 6, 32'hABCD, 0);
    step(1, 32'h0063D863, 32'h204, 0, 0, 0, 0, 0);
    step(1, 32'h0063D863, 32'h204, 0, 0, 0, 0, 0);
    step(1, 32'h0063D863, 32'h204, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // flush with accept and writeback, then read x9 back via add x10,x9,x0
    step(1, 32'h7FF00293, 32'h300, 1, 1, 9, 32'hCAFE, 1);
    step(1, 32'h00048533, 32'h304, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // addi x17,x0,1; write x17; read x17 via add x1,x17,x0; opcode 0x7F
    step(1, 32'h00100893, 32'h400, 0, 1, 17, 32'h5, 1);
    step(1, 32'h000880B3, 32'h404, 0, 0, 0, 0, 1);
    step(1, 32'hFFFFFFFF, 32'h408, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) rand_step();
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("d32_queue_drained", q0.size(), 0);
    chk("d16_queue_drained", q1.size(), 0);
    // reset while a bundle is stalled
    step(1, 32'h00530333, 32'h500, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, pipelined successor to the combinational ID decode stage of the RV32 core.
- Decodes RV32I/RV32E instructions, reads the integer register file and generates sign-extended immediates and ALU control.
- Results are registered into a single output stage with valid/ready handshakes on both sides.
- Sits between IF and EX. Accepts writeback from WB and supports flush from branch resolution.

Parameters:
- XLEN, 32, datapath/PC/immediate width; legal values 32 or 64.
- NREGS, 32, number of architectural registers; 32 for RV32I, 16 for RV32E.
- RA_W, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  IF presents an instruction
- o_ready  out  1  stage can accept
- i_instr  in  32  instruction word
- i_pc  in  XLEN  PC of i_instr
- i_flush  in  1  kill held/incoming instruction
- i_wr  in  1  writeback enable
- i_rd_addr  in  5  writeback destination
- i_write_data  in  XLEN  writeback value
- o_valid  out  1  decoded bundle valid
- i_ready  in  1  EX accepts bundle
- o_pc  out  XLEN  registered PC
- o_rs1_data, o_rs2_data  out  XLEN  operand values
- o_rs1_addr, o_rs2_addr, o_rd_addr  out  5  register fields
- o_imm_data  out  XLEN  sign-extended immediate
- o_opcode  out  7  instr[6:0]
- o_func3  out  3  instr[14:12]
- o_alu_ctrl  out  4  ALU operation
- o_illegal  out  1  unsupported opcode or register index >= NREGS

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous and active-high, sampled on the rising edge of clk. On reset, o_valid=0, every other output=0, and all registers x0..x(NREGS-1)=0.
- Handshake: o_ready = !o_valid || i_ready. An instruction is accepted on a rising edge where i_valid && o_ready.
  - On accept, the output register captures the decoded bundle and o_valid=1 from the next cycle. Latency is 1 cycle.
  - If i_ready=0 and o_valid=1, all outputs hold and no input is accepted.
  - If EX consumes the bundle and no new accept occurs in the same cycle, o_valid=0 next cycle.
- Flush: i_flush=1 forces o_valid=0 next cycle and drops any same-cycle accept. Flush takes priority over accept. Writeback is unaffected by flush.
- Register file:
  - NREGS x XLEN storage with combinational read and write on the clock edge when i_wr=1 and i_rd_addr!=0 and i_rd_addr<NREGS.
  - x0 always reads 0.
  - Out-of-range read indices return 0.
- Immediates: decoded by format and sign-extended from instr[31] to XLEN.
  - I: LOAD/OP-IMM/JALR
  - S: STORE
  - B: BRANCH
  - U: LUI/AUIPC
  - J: JAL
  - OP (R-type) and unknown opcodes give imm=0.
- o_alu_ctrl:
  - OP: {instr[30], func3}.
  - OP-IMM: {instr[30] only when func3=101, func3}.
  - All other opcodes: 4'b0000 (ADD).
- o_illegal=1 when either of the following holds; the bundle still flows with o_valid.
  - The opcode is not one of 0x37, 0x17, 0x6F, 0x67, 0x63, 0x03, 0x23, 0x13, 0x33.
  - Any used rs1, rs2 or rd field is >= NREGS.
- Simultaneous writeback and read of the same register at accept: read-before-write. The old value is captured unless ID_BYPASS_EN is defined.
- Reset mid-stall: the bundle is discarded and o_valid=0.

Optional Feature:
- Macro: ID_BYPASS_EN.
- Defined:
  - At accept, if i_wr && i_rd_addr==rsN && rsN!=0, o_rsN_data captures i_write_data.
  - While stalled (o_valid && !i_ready), a matching writeback also updates the held o_rsN_data.
- Undefined:
  - Operands come only from the register file before the write.
  - Held operands never change during a stall.

Test Plan:
1. Reset, then accept 0x7FF00293 (addi x5,x0,2047) -> one cycle later o_valid=1, o_imm_data=0x000007FF, o_rd_addr=5, o_opcode=0x13, o_alu_ctrl=0000, o_illegal=0.
2. Write x5=0x7FF and x6=0x10 via writeback, then accept 0x00530333 (add x6,x6,x5) -> o_rs1_data=0x10, o_rs2_data=0x7FF, o_alu_ctrl=0000.
   - Repeat with i_wr x5=0x123 in the accept cycle: o_rs2_data=0x123 with ID_BYPASS_EN, 0x7FF without it.
3. Accept 0xFE5FF3EF (jal x7,-28) then 0x0063D863 (bge x7,x6,16) back-to-back with i_ready=1.
   - JAL bundle: o_imm_data=0xFFFFFFE4, rd=7.
   - BGE bundle: o_imm_data=0x00000010, func3=101, rs1=7, rs2=6.
   - o_valid is continuous across both.
4. Hold i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0, outputs frozen; the second instruction appears exactly one cycle after i_ready returns to 1.
5. Assert i_flush with i_valid=1 -> o_valid=0 next cycle; a writeback issued in the same cycle still updates the register file (checked by a later read).
6. NREGS=16: accept 0x00100893 (addi x17,x0,1) -> o_illegal=1 and x17 is never written; opcode 0x7F -> o_illegal=1, o_imm_data=0.
